mont_converter: RTL and testbench

- Iterative, bit-serial converter between the normal and Montgomery domains, with R = 2^ITER.
- Encode computes a·R mod p. It is the producer that feeds Montgomery-form operands into the Montgomery multiplier datapath.
- Decode computes a·R^-1 mod p. It returns Montgomery-form results to the normal domain at the NTT output.
- Uses a valid/ready handshake on both sides and processes one operand at a time.

---
 rtl/mont_converter_pkg.sv | 23 ++
 rtl/mont_converter_if.sv | 32 +++
 rtl/mont_converter_step.sv | 36 +++
 rtl/mont_converter.sv | 99 +++++++++
 tb/tb_mont_converter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_converter_pkg.sv
//------------------------------------------------------------------------------
// Module   : mont_converter_pkg
// Brief    : Shared widths, mode encodings and FSM state codes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mont_converter_pkg;

    localparam int DATAWIDTH = 8;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mont_converter_if.sv
//------------------------------------------------------------------------------
// Module   : mont_converter_if
// Brief    : Operand-in / result-out valid-ready bus of the converter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mont_converter_if #(
    parameter int DW = mont_converter_pkg::DATAWIDTH
);
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic [DW-1:0] p;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    modport master (
        output in_valid, in_mode, in_data, p, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_data, p, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/mont_converter_step.sv
//------------------------------------------------------------------------------
// Module   : mont_shift_step
// Brief    : One modular doubling (encode) or halving (decode) step, x < p kept.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mont_shift_step
    import mont_converter_pkg::*;
#(
    parameter int DW = DATAWIDTH
) (
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] p_i,
    input  logic          mode_i,
    output logic [DW-1:0] x_next_o
);
    logic [DW:0] w_p_ext;
    logic [DW:0] w_t_enc;
    logic [DW:0] w_t_dec;

    always_comb begin
        w_p_ext = {1'b0, p_i};
        w_t_enc = {x_i, 1'b0};
        // Odd p makes x + p even whenever x is odd, so the halving is exact.
        w_t_dec = {1'b0, x_i} + (x_i[0] ? w_p_ext : '0);
        if (mode_i == MODE_ENC) begin
            x_next_o = (w_t_enc >= w_p_ext) ? DW'(w_t_enc - w_p_ext) : DW'(w_t_enc);
        end else begin
            x_next_o = DW'(w_t_dec >> 1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mont_converter.sv
//------------------------------------------------------------------------------
// Module   : mont_converter
// Brief    : Bit-serial normal <-> Montgomery domain converter, R = 2^ITER.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mont_converter
    import mont_converter_pkg::*;
#(
    parameter int DW   = DATAWIDTH,
    parameter int ITER = DW,
    parameter int CW   = $clog2(ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    mont_converter_if.slave  bus
);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] p_q, p_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic [DW-1:0] w_x_next;
    logic [DW-1:0] w_in_red;

    mont_shift_step #(.DW(DW)) u_step (
        .x_i      (x_q),
        .p_i      (p_q),
        .mode_i   (mode_q),
        .x_next_o (w_x_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            p_q        <= '0;
            mode_q     <= MODE_ENC;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            p_q        <= p_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        p_d        = p_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        // Inputs up to 2p are folded into [0, p) with a single subtract.
        w_in_red   = (bus.in_data >= bus.p) ? (bus.in_data - bus.p) : bus.in_data;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mode_d  = bus.in_mode;
                    p_d     = bus.p;
                    x_d     = w_in_red;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d   = w_x_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    out_data_d = w_x_next;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
        bus.out_data  = out_data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mont_converter.sv
//------------------------------------------------------------------------------
// Module   : tb_mont_converter
// Brief    : Scoreboard bench for mont_converter at DW = ITER = 8 (R = 256).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mont_converter;
    localparam int DW = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [DW-1:0] sb[$];

    mont_converter_if #(.DW(DW)) bus ();

    mont_converter #(.DW(DW), .ITER(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a*R mod p directly, or the y in [0,p) with y*R = a mod p.
    function automatic logic [DW-1:0] ref_conv(input bit m, input int a, input int pp);
        int r;
        r = a % pp;
        if (!m) return DW'((r * 256) % pp);
        for (int y = 0; y < pp; y++) begin
            if (((y * 256) % pp) == r) return DW'(y);
        end
        return '0;
    endfunction

    task automatic do_op(input bit m, input logic [DW-1:0] d, input logic [DW-1:0] pp,
                         input int stall, output logic [DW-1:0] got,
                         output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        got = '0;
        lat = 0;
        sb.push_back(ref_conv(m, int'(d), int'(pp)));
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tmo = 1'b1;
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.p         = pp;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_mode  = ~m;
        bus.in_data  = DW'($urandom);
        bus.p        = DW'($urandom);
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 50);
        if (!bus.out_valid) begin
            tmo = 1'b1;
            return;
        end
        repeat (stall) @(negedge clk);
        bus.out_ready = 1'b1;
        got = bus.out_data;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b data=%0d, need 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        rst = 1'b0;
    endtask

    task automatic run_one(input string name, input bit m, input logic [DW-1:0] d,
                           input logic [DW-1:0] pp, input int stall, input int need_lat);
        logic [DW-1:0] got, exp;
        int lat;
        bit tmo;
        do_op(m, d, pp, stall, got, lat, tmo);
        exp = sb.pop_front();
        n_cmp++;
        if (tmo || got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (timeout=%0b), need %0d", name, got, tmo, exp);
        end
        if (need_lat > 0) begin
            n_cmp++;
            if (lat !== need_lat) begin
                n_err++;
                $display("FAIL %s_latency: got %0d, need %0d", name, lat, need_lat);
            end
        end
    endtask

    task automatic test_encode();
        run_one("enc3", 1'b0, 8'd3, 8'd13, 0, 9);
        run_one("enc0", 1'b0, 8'd0, 8'd13, 0, 0);
        run_one("enc7", 1'b0, 8'd7, 8'd13, 0, 0);
    endtask

    task automatic test_decode();
        run_one("dec1", 1'b1, 8'd1, 8'd13, 0, 9);
        run_one("dec12", 1'b1, 8'd12, 8'd13, 0, 0);
        run_one("dec11", 1'b1, 8'd11, 8'd13, 0, 0);
    endtask

    task automatic test_unreduced();
        run_one("enc15", 1'b0, 8'd15, 8'd13, 0, 0);
        run_one("enc2", 1'b0, 8'd2, 8'd13, 0, 0);
        run_one("enc25", 1'b0, 8'd25, 8'd13, 0, 0);
        run_one("dec25", 1'b1, 8'd25, 8'd13, 0, 0);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp;
        int n;
        bit bad;
        sb.push_back(ref_conv(1'b0, 7, 13));
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = 8'd7;
        bus.p         = 8'd13;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        exp = sb[0];
        bad = !bus.out_valid;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0)
                bad = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL bp_hold: got vld=%b data=%0d rdy=%b, need 1 %0d 0",
                     bus.out_valid, bus.out_data, bus.in_ready, exp);
        end
        bus.out_ready = 1'b1;
        exp = sb.pop_front();
        n_cmp++;
        if (bus.out_data !== exp || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_data: got %0d vld=%b, need %0d", bus.out_data, bus.out_valid, exp);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b rdy=%b, need 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit stale;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b0;
        bus.in_data  = 8'd3;
        bus.p        = 8'd13;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid: got vld=%b busy=%b rdy=%b, need 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale) begin
            n_err++;
            $display("FAIL rst_no_stale: got out_valid=1 after abort, need 0");
        end
        run_one("rst_enc3", 1'b0, 8'd3, 8'd13, 0, 9);
    endtask

    task automatic test_random();
        logic [DW-1:0] got, exp, pp, a;
        int lat;
        bit tmo, m;
        for (int i = 0; i < 3000; i++) begin
            pp = DW'($urandom_range(1, 63) * 2 + 1);
            a  = DW'($urandom_range(0, int'(pp) - 1));
            m  = 1'($urandom_range(0, 1));
            do_op(m, a, pp, $urandom_range(0, 3), got, lat, tmo);
            exp = sb.pop_front();
            n_cmp++;
            if (tmo || got !== exp) begin
                n_err++;
                $display("FAIL rand[%0d] m=%0b a=%0d p=%0d: got %0d, need %0d",
                         i, m, a, pp, got, exp);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.p         = 8'd13;
        bus.out_ready = 1'b0;
        test_reset();
        test_encode();
        test_decode();
        test_unreduced();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
